bcd_timer_ssd: RTL
==================

Name: bcd_timer_ssd

Overview:
- Parametrised successor to the fixed 50-second down counter: a DIGITS-wide BCD timer with runtime preset, up/down mode, start/pause/resume control and an internal step prescaler.
- Drives a multiplexed active-low seven-segment display directly, with optional leading-zero blanking, plus a 16-LED done indicator.
- The display blinks on expiry.
- Sits between the debounced/one-pulsed button logic and the board display pins.

Parameters:
- DIGITS, 4, number of BCD digits (2..4); also the number of display anodes.
- TICK_DIV, 100000000, clk cycles per count step (≥2).
- SCAN_DIV, 100000, clk cycles each anode stays active (≥1).
- LZB, 1, 1 = blank leading zero digits (digit 0 never blanked).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start_pause  in  1  single-cycle pulse; start / pause / resume / acknowledge.
- load  in  1  single-cycle pulse; abort and return to IDLE.
- mode  in  1  0 = count down from preset to 0; 1 = count up from 0 to preset.
- preset  in  4*DIGITS  BCD target, digit 0 in bits [3:0].
- done  out  1  high in DONE.
- led  out  16  all ones in DONE, else 0.
- ssd  out  DIGITS  one-hot-low anode select.
- D  out  8  segments {a,b,c,d,e,f,g,dp}, 0 = lit.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset values: state=IDLE, count=0, prescaler=0, blink=0, scan index=0, done=0, led=0, ssd={1..1,0}, D=8'b00000011 (digit 0 showing "0").
- Preset sanitising: any preset nibble >9 is treated as 9.
- States: IDLE, RUN, PAUSE, DONE. Registered, all on posedge clk.
- IDLE:
  - count loads every cycle with (mode ? 0 : sanitised preset).
  - start_pause -> RUN with prescaler=0.
- RUN:
  - prescaler counts 0..TICK_DIV-1; tick = (prescaler==TICK_DIV-1), and the prescaler wraps to 0 on tick.
  - On tick, count steps by one in BCD: down = digit 0->9 with borrow to the next digit; up = digit 9->0 with carry.
  - If the stepped value equals the terminal value (0 in down mode, sanitised preset in up mode), go to DONE on the same edge.
  - start_pause -> PAUSE. The prescaler freezes and keeps its value.
- Terminal at start: if count already equals the terminal value on entry to RUN (preset 0 in either mode), go to DONE on the next edge without ticking.
- PAUSE:
  - count and prescaler hold.
  - start_pause -> RUN, resuming from the frozen prescaler value.
- DONE:
  - count holds; done=1; led=16'hFFFF.
  - prescaler free-runs; blink toggles on each tick; blink=1 forces D=8'hFF.
  - start_pause -> IDLE.
- load: in any state, forces IDLE next edge and clears prescaler and blink. load wins over a simultaneous start_pause.
- mode changes are sampled only in IDLE. Changes in RUN, PAUSE or DONE are ignored until the next IDLE.
- Tick coinciding with start_pause in RUN: the step is applied AND the state goes to PAUSE. If that step reaches terminal, DONE wins.
- Display scan:
  - Scan counter counts 0..SCAN_DIV-1; at wrap, the digit index advances 0..DIGITS-1 and wraps.
  - ssd is low only at the index bit. Scan runs in every state and is independent of count state.
  - D is a registered-free decode of the selected count digit: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001, other=11111110.
  - With LZB=1, digit k>0 is blanked (8'hFF) when it and all higher digits are 0.
- Output paths: done and led are decoded from the state register (no extra latency). ssd and D follow the scan index and count combinationally.

Decomposition:
- Package bcd_timer_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE};
  - segment constants SS_0..SS_9, SEG_BLANK=8'hFF, SEG_ERR=8'b11111110;
  - function bcd_sanitise(nibble).
- Sub-module bcd_digit_cnt:
  - one digit with load, en, up/down, cin and cout (borrow/carry);
  - instantiated DIGITS times in a generate chain.

Test Plan:
All cases use DIGITS=2, TICK_DIV=4, SCAN_DIV=2, LZB=1.
- Down: preset=8'h12, mode=0, start_pause -> count 12,11,10,09 every 4 cycles … reaches 00 in 48 cycles after start; done=1, led=FFFF.
- Up: preset=8'h03, mode=1, start_pause -> count 00,01,02,03; DONE on the 03 step; further ticks do not change count; D toggles with 8'hFF each tick.
- Pause mid-step: start, wait 6 cycles (count 11, prescaler=1), pulse start_pause.
  - Requirement: hold 20 cycles, count stays 11.
  - Requirement: after resume, the next step lands exactly 3 cycles after resume.
- load during RUN with simultaneous start_pause: IDLE next edge, count reloaded to 12, prescaler 0. In DONE, start_pause -> IDLE.
- Edge cases: preset=8'h00, mode=0 -> DONE one cycle after start. preset=8'hFA sanitised to 99. Asserting rst mid-RUN clears count to 0 and ssd to 2'b10 immediately (asynchronous).
- Scan/LZB: count=05 -> anode0 shows 01001001, anode1 shows FF. count=10 -> anode1 shows 10011111, anode0 shows 00000011. Each anode is active for 2 cycles.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_timer_pkg
// Shared definitions for the BCD timer / seven-segment display block:
//   - state_t      : timer control states
//   - SS_0..SS_9   : active-low segment patterns {a,b,c,d,e,f,g,dp}
//   - SEG_BLANK    : all segments off
//   - SEG_ERR      : pattern shown for a non-BCD nibble (only dp lit)
//   - BCD_MAX      : largest legal BCD digit
//   - bcd_sanitise : clamps a nibble into the BCD range
//   - seg_decode   : BCD digit to segment pattern
// ---------------------------------------------------------------------------
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [7:0] SS_0      = 8'b00000011;
    localparam logic [7:0] SS_1      = 8'b10011111;
    localparam logic [7:0] SS_2      = 8'b00100101;
    localparam logic [7:0] SS_3      = 8'b00001101;
    localparam logic [7:0] SS_4      = 8'b10011001;
    localparam logic [7:0] SS_5      = 8'b01001001;
    localparam logic [7:0] SS_6      = 8'b01000001;
    localparam logic [7:0] SS_7      = 8'b00011111;
    localparam logic [7:0] SS_8      = 8'b00000001;
    localparam logic [7:0] SS_9      = 8'b00001001;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ERR   = 8'b11111110;

    // Any nibble above 9 is treated as 9 so the counter never holds a
    // non-BCD digit.
    function automatic logic [3:0] bcd_sanitise(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SS_0;
            4'd1:    seg = SS_1;
            4'd2:    seg = SS_2;
            4'd3:    seg = SS_3;
            4'd4:    seg = SS_4;
            4'd5:    seg = SS_5;
            4'd6:    seg = SS_6;
            4'd7:    seg = SS_7;
            4'd8:    seg = SS_8;
            4'd9:    seg = SS_9;
            default: seg = SEG_ERR;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// ---------------------------------------------------------------------------
// bcd_digit_cnt
// One BCD digit of the timer count, chained through cin/cout.
//   clk, rst   : clock, asynchronous active-low reset (digit clears to 0)
//   load       : load_val is captured (has priority over en)
//   load_val   : 4-bit value to load
//   en         : apply step_val this edge
//   up         : 1 = count up (9 -> 0 carries), 0 = count down (0 -> 9 borrows)
//   cin        : step request from the digit below (tie high on digit 0)
//   q          : current digit value
//   step_val   : value this digit takes if the chain steps now
//   cout       : carry (up) or borrow (down) towards the next digit
// ---------------------------------------------------------------------------
module bcd_digit_cnt
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q,
    output logic [3:0] step_val,
    output logic       cout
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // step_val is exposed even when en is low so the parent can see the
    // post-step count and detect the terminal value on the same edge.
    always_comb begin
        step_val = digit_q;
        cout     = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit_q >= BCD_MAX) begin
                    step_val = 4'd0;
                    cout     = 1'b1;
                end else begin
                    step_val = digit_q + 4'd1;
                end
            end else begin
                if (digit_q == 4'd0) begin
                    step_val = BCD_MAX;
                    cout     = 1'b1;
                end else begin
                    step_val = digit_q - 4'd1;
                end
            end
        end

        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (en) begin
            digit_d = step_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q = digit_q;

endmodule

// File: rtl/bcd_timer_ssd.sv
// ---------------------------------------------------------------------------
// bcd_timer_ssd
// DIGITS-wide BCD timer with preset, up/down mode, start/pause/resume and a
// step prescaler, driving a multiplexed active-low seven-segment display.
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   start_pause  : one-cycle pulse; start / pause / resume / acknowledge done
//   load         : one-cycle pulse; abort to IDLE (beats start_pause)
//   mode         : 0 = count down preset->0, 1 = count up 0->preset
//   preset       : BCD target, digit 0 in [3:0]; nibbles >9 read as 9
//   done         : high while in DONE
//   led          : 16'hFFFF while in DONE, else 0
//   ssd          : one-hot-low anode select
//   D            : segments {a,b,c,d,e,f,g,dp}, 0 = lit
// Parameters: DIGITS (2..4), TICK_DIV (clk per step, >=2),
//             SCAN_DIV (clk per anode, >=1), LZB (1 = blank leading zeros)
// ---------------------------------------------------------------------------
module bcd_timer_ssd
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000,
    parameter int LZB      = 1
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_pause,
    input  logic                  load,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   preset,
    output logic                  done,
    output logic [15:0]           led,
    output logic [DIGITS-1:0]     ssd,
    output logic [7:0]            D
);

    localparam int CW     = 4 * DIGITS;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = $clog2(DIGITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  presc_q, presc_d;
    logic               blink_q, blink_d;
    logic               mode_q, mode_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    // count_q is the concatenation of the per-digit registers held inside
    // the bcd_digit_cnt instances; stepped is the value after one step.
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      stepped;
    logic [DIGITS:0]    carry;
    logic               carry_unused;

    logic [CW-1:0]      preset_san;
    logic [CW-1:0]      load_val;
    logic [CW-1:0]      term_val;
    logic               tick;
    logic               cnt_load;
    logic               cnt_step;

    logic [3:0]         sel_digit;
    logic               sel_blank;

    // Clamp every preset nibble into BCD before it is loaded or compared.
    always_comb begin
        preset_san = '0;
        for (int k = 0; k < DIGITS; k++) begin
            preset_san[4*k +: 4] = bcd_sanitise(preset[4*k +: 4]);
        end
    end

    // The load value follows the live mode input (only used in IDLE); the
    // terminal value follows the mode captured in IDLE so that mode changes
    // while running have no effect.
    assign load_val = mode   ? '0 : preset_san;
    assign term_val = mode_q ? preset_san : '0;
    assign tick     = (presc_q == TICK_LAST);

    // Digit 0 always steps when enabled; each higher digit steps on the
    // carry/borrow from below.
    assign carry[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cnt u_digit (
            .clk      (clk),
            .rst      (rst),
            .load     (cnt_load),
            .load_val (load_val[4*k +: 4]),
            .en       (cnt_step),
            .up       (mode_q),
            .cin      (carry[k]),
            .q        (count_q[4*k +: 4]),
            .step_val (stepped[4*k +: 4]),
            .cout     (carry[k+1])
        );
    end

    // The top digit's carry/borrow has no consumer: the count stops at its
    // terminal value before it could wrap.
    assign carry_unused = carry[DIGITS];

    // Control next-state logic. load is applied last so it overrides every
    // other decision, including a simultaneous start_pause.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        blink_d  = blink_q;
        mode_d   = mode_q;
        cnt_load = 1'b0;
        cnt_step = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_load = 1'b1;
                mode_d   = mode;
                presc_d  = '0;
                blink_d  = 1'b0;
                if (start_pause) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                // A preset of zero leaves the count at its terminal value on
                // entry, so finish without ticking.
                if (count_q == term_val) begin
                    state_d = DONE;
                end else begin
                    presc_d  = tick ? '0 : presc_q + TICK_W'(1);
                    cnt_step = tick;
                    if (tick && (stepped == term_val)) begin
                        state_d = DONE;
                    end else if (start_pause) begin
                        state_d = PAUSE;
                    end
                end
            end

            PAUSE: begin
                if (start_pause) begin
                    state_d = RUN;
                end
            end

            DONE: begin
                presc_d = tick ? '0 : presc_q + TICK_W'(1);
                if (tick) begin
                    blink_d = ~blink_q;
                end
                if (start_pause) begin
                    state_d = IDLE;
                    presc_d = '0;
                    blink_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d  = IDLE;
            presc_d  = '0;
            blink_d  = 1'b0;
            cnt_step = 1'b0;
        end
    end

    // Anode scan: hold each anode for SCAN_DIV cycles, then move on.
    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            blink_q <= 1'b0;
            mode_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            blink_q <= blink_d;
            mode_q  <= mode_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
        end
    end

    assign done = (state_q == DONE);
    assign led  = done ? 16'hFFFF : 16'h0000;
    assign ssd  = ~(DIGITS'(1) << idx_q);

    // Segment decode of the selected digit. A digit above 0 is blanked when
    // it and everything above it are zero; digit 0 always shows.
    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_digit = count_q[4*k +: 4];
                sel_blank = (LZB != 0) && (k != 0) && ((count_q >> (4*k)) == '0);
            end
        end
        if (blink_q || sel_blank) begin
            D = SEG_BLANK;
        end else begin
            D = seg_decode(sel_digit);
        end
    end

endmodule
